// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: a 4-bit state register with
// combinational decode of every datapath control from state and inputs.
module mips_mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic       retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = S_FETCH;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        illegal_op  = 1'b0;
        retired     = 1'b0;

        // Reset holds every control quiet, whatever state is registered.
        if (rst_n) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    state_d = S_FETCH;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        alu_src_b = 2'b01;
                        state_d   = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    unique case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        OP_ADDI:      state_d = S_ADDIEX;
                        default: begin
                            illegal_op = 1'b1;
                            state_d    = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    state_d = mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retired    = 1'b1;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    retired   = mem_ready;
                    state_d   = mem_ready ? S_FETCH : S_MEMWR;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    state_d   = S_ALUWB;
                    unique case (funct)
                        FN_AND:  alu_control = ALU_AND;
                        FN_OR:   alu_control = ALU_OR;
                        FN_ADD:  alu_control = ALU_ADD;
                        FN_SUB:  alu_control = ALU_SUB;
                        FN_SLT:  alu_control = ALU_SLT;
                        default: begin
                            alu_control = ALU_BAD;
                            illegal_op  = 1'b1;
                            state_d     = S_FETCH;
                        end
                    endcase
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retired   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_control = ALU_SUB;
                    pc_src      = 2'b01;
                    pc_write    = zero;
                    retired     = 1'b1;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                    retired   = 1'b1;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                    retired  = 1'b1;
                end
                default: begin
                    alu_control = 4'b0000;
                    state_d     = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: packs all outputs into one vector
// and compares it per cycle against hand-computed expectations.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       reg_write, reg_dst, mem_to_reg, illegal_op, retired;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_control(alu_control),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op),
        .retired    (retired)
    );

    wire [18:0] outv = {mem_req, mem_write, iord, ir_write, pc_write,
                        pc_src, alu_src_a, alu_src_b, alu_control,
                        reg_write, reg_dst, mem_to_reg, illegal_op,
                        retired};

    // Field order: req wr iord irw pcw pcsrc a b alu rw rd m2r ill ret
    function automatic logic [18:0] o(
        input logic req, input logic wr, input logic io,
        input logic irw, input logic pcw, input logic [1:0] pcs,
        input logic a, input logic [1:0] b, input logic [3:0] alu,
        input logic rw, input logic rd, input logic m2r,
        input logic ill, input logic ret);
        return {req, wr, io, irw, pcw, pcs, a, b, alu,
                rw, rd, m2r, ill, ret};
    endfunction

    task automatic check(input string tag, input logic [18:0] got,
                         input logic [18:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %b want %b", tag, got, exp);
        end
    endtask

    // Sample at the falling edge, then advance past the rising edge.
    task automatic tick(input string tag, input logic [18:0] exp);
        @(negedge clk);
        check(tag, outv, exp);
        @(posedge clk);
        #1;
    endtask

    localparam logic [3:0] ADD = 4'b0010;
    logic [18:0] IDLE, FRDY, FWAIT, DEC;

    initial begin
        IDLE  = o(0,0,0,0,0,2'b00,0,2'b00,ADD,0,0,0,0,0);
        FRDY  = o(1,0,0,1,1,2'b00,0,2'b01,ADD,0,0,0,0,0);
        FWAIT = o(1,0,0,0,0,2'b00,0,2'b00,ADD,0,0,0,0,0);
        DEC   = o(0,0,0,0,0,2'b00,0,2'b11,ADD,0,0,0,0,0);

        rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        opcode = 6'b100011; funct = 6'b000000;
        @(posedge clk); #1;
        tick("rst_nordy", IDLE);
        mem_ready = 1'b1;
        tick("rst_rdy", IDLE);

        // LW, zero-wait: 5 cycles
        rst_n = 1'b1;
        tick("lw_fetch", FRDY);
        tick("lw_dec", DEC);
        tick("lw_adr", o(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,0,0,0));
        tick("lw_rd", o(1,0,1,0,0,2'b00,0,2'b00,ADD,0,0,0,0,0));
        tick("lw_wb", o(0,0,0,0,0,2'b00,0,2'b00,ADD,1,0,1,0,1));

        // FETCH stalls while memory is not ready
        opcode = 6'b000000; funct = 6'b101010; mem_ready = 1'b0;
        tick("f_wait", FWAIT);
        mem_ready = 1'b1;
        tick("slt_fetch", FRDY);
        tick("slt_dec", DEC);
        tick("slt_exec", o(0,0,0,0,0,2'b00,1,2'b00,4'b0111,0,0,0,0,0));
        tick("slt_wb", o(0,0,0,0,0,2'b00,0,2'b00,ADD,1,1,0,0,1));

        // BEQ taken then not taken
        opcode = 6'b000100; zero = 1'b1;
        tick("beq1_fetch", FRDY);
        tick("beq1_dec", DEC);
        tick("beq1_br", o(0,0,0,0,1,2'b01,1,2'b00,4'b0110,0,0,0,0,1));
        zero = 1'b0;
        tick("beq0_fetch", FRDY);
        tick("beq0_dec", DEC);
        tick("beq0_br", o(0,0,0,0,0,2'b01,1,2'b00,4'b0110,0,0,0,0,1));
        mem_ready = 1'b0;
        tick("beq0_next", FWAIT);

        // SW with three wait cycles: 7 cycles total
        mem_ready = 1'b1; opcode = 6'b101011;
        tick("sw_fetch", FRDY);
        tick("sw_dec", DEC);
        tick("sw_adr", o(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,0,0,0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            tick("sw_wait", o(1,1,1,0,0,2'b00,0,2'b00,ADD,0,0,0,0,0));
        mem_ready = 1'b1;
        tick("sw_done", o(1,1,1,0,0,2'b00,0,2'b00,ADD,0,0,0,0,1));

        // Illegal opcode
        opcode = 6'b111111;
        tick("ill_fetch", FRDY);
        tick("ill_dec", o(0,0,0,0,0,2'b00,0,2'b11,ADD,0,0,0,1,0));
        mem_ready = 1'b0;
        tick("ill_back", FWAIT);

        // Illegal funct
        mem_ready = 1'b1; opcode = 6'b000000; funct = 6'b000111;
        tick("badfn_fetch", FRDY);
        tick("badfn_dec", DEC);
        tick("badfn_exec", o(0,0,0,0,0,2'b00,1,2'b00,4'b1111,0,0,0,1,0));
        mem_ready = 1'b0;
        tick("badfn_back", FWAIT);

        // Jump
        mem_ready = 1'b1; opcode = 6'b000010;
        tick("j_fetch", FRDY);
        tick("j_dec", DEC);
        tick("j_jump", o(0,0,0,0,1,2'b10,0,2'b00,ADD,0,0,0,0,1));

        // ADDI
        opcode = 6'b001000;
        tick("addi_fetch", FRDY);
        tick("addi_dec", DEC);
        tick("addi_ex", o(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,0,0,0));
        tick("addi_wb", o(0,0,0,0,0,2'b00,0,2'b00,ADD,1,0,0,0,1));

        // Reset during a MEMRD wait
        opcode = 6'b100011;
        tick("lwr_fetch", FRDY);
        tick("lwr_dec", DEC);
        tick("lwr_adr", o(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,0,0,0));
        mem_ready = 1'b0;
        tick("lwr_wait", o(1,0,1,0,0,2'b00,0,2'b00,ADD,0,0,0,0,0));
        rst_n = 1'b0;
        tick("lwr_rst", IDLE);
        rst_n = 1'b1;
        tick("lwr_after", FWAIT);
        mem_ready = 1'b1;
        tick("lwr_refetch", FRDY);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
